fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 4'h0, SHALL be the program counter value loaded at reset.
REQ-002 Port clk_cpu  input  1  SHALL be the single CPU clock; all state updates occur on its rising edge.
REQ-003 Port reset  input  1  SHALL be the reset: synchronous, active-low.
REQ-004 Port stall  input  1  SHALL freeze the sequencer when high.
REQ-005 Port halt_req  input  1  SHALL request a halt after the current EXEC cycle.
REQ-006 Port resume  input  1  SHALL restart fetching from the HALT state.
REQ-007 Port jmp_en  input  1  SHALL select jmp_adrs as the next PC; sampled in EXEC only.
REQ-008 Port jmp_adrs  input  4  SHALL be the jump target address.
REQ-009 Port rom_dat  input  8  SHALL be the instruction word from the combinational ROM at rom_adrs.
REQ-010 Port rom_adrs  output  4  SHALL be the ROM address, equal to pc at all times.
REQ-011 Port pc_out  output  4  SHALL be the current program counter.
REQ-012 Port op  output  4  SHALL be ir[7:4] of the latched instruction register.
REQ-013 Port im  output  4  SHALL be ir[3:0] of the latched instruction register.
REQ-014 Port exec_strobe  output  1  SHALL be high for exactly the cycles in which the state is EXEC and stall is low.
REQ-015 Port halted  output  1  SHALL be high while the state is HALT.
REQ-016 Port instr_cnt  output  8  SHALL count retired instructions.

Function
REQ-017 FSM states SHALL be FETCH, DECODE, EXEC and HALT; exactly one is active per cycle.
REQ-018 FETCH: SHALL latch rom_dat into ir at the clock edge, then go to DECODE.
REQ-019 DECODE: SHALL hold ir and pc; op/im valid; next state EXEC.
REQ-020 EXEC: SHALL assert exec_strobe, update pc to jmp_adrs if jmp_en else pc+1, increment instr_cnt, then go to HALT if halt_req else FETCH.
REQ-021 PC increment SHALL be modulo 16; 4'hF+1 -> 4'h0, with no other side effect.
REQ-022 instr_cnt SHALL increment modulo 256; 8'hFF -> 8'h00.
REQ-023 Latency SHALL be 3 cycles per instruction with no stall: FETCH, DECODE, EXEC; throughput is one instruction per 3 cycles.
REQ-024 stall high in FETCH, DECODE or EXEC SHALL hold state, pc, ir and instr_cnt unchanged; exec_strobe is low; jmp_en and halt_req are ignored that cycle.
REQ-025 HALT: pc, ir and instr_cnt SHALL hold; on resume high go to FETCH at the next edge; stall SHALL be ignored in HALT.
REQ-026 resume SHALL be ignored in every state except HALT.
REQ-027 halt_req and jmp_en both high in EXEC SHALL apply the jump and then enter HALT; pc_out in HALT equals jmp_adrs.
REQ-028 halt_req outside EXEC SHALL have no effect; it is not remembered.
REQ-029 jmp_en outside EXEC SHALL have no effect.

Reset
REQ-030 reset low at a clock edge SHALL force state=FETCH, pc=RESET_PC, ir=8'h00, instr_cnt=8'h00; outputs then read exec_strobe=0, halted=0, op=0, im=0.
REQ-031 reset SHALL take priority over stall, halt_req, resume and jmp_en.
REQ-032 reset asserted mid-instruction (DECODE or EXEC) SHALL abort it; no pc update and no instr_cnt increment occur from that cycle.
REQ-033 After reset deasserts, the first ROM fetch SHALL use address RESET_PC in the first cycle.

Verification
REQ-034 Reset, then rom_dat=8'h3F at pc 0 with no stall -> ir=8'h3F after cycle 1; op=4'h3, im=4'hF; exec_strobe high in cycle 3; pc=1 and instr_cnt=1 after cycle 3.
REQ-035 Free-run 16 instructions from pc 4'h0 -> pc wraps 4'hF -> 4'h0 and instr_cnt=16; exec_strobe pulses every 3rd cycle.
REQ-036 jmp_en=1, jmp_adrs=4'hA during EXEC at pc 4'h2 -> next FETCH address is 4'hA; jmp_en=1 during DECODE -> ignored, pc becomes 4'h3.
REQ-037 stall=1 for 5 cycles in DECODE -> state, pc and ir unchanged and no exec_strobe; EXEC follows one cycle after stall drops.
REQ-038 halt_req=1 and jmp_en=1 (jmp_adrs=4'h7) in EXEC -> halted=1, pc_out=4'h7, held through 10 idle cycles and resume in FETCH ignored; resume=1 -> FETCH at 4'h7 next cycle.
REQ-039 reset low during EXEC with pc=4'h5 and instr_cnt=8'h09 -> next cycle pc=RESET_PC, instr_cnt=0, state FETCH, exec_strobe=0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Three-phase instruction fetch sequencer: FETCH latches the ROM word, DECODE presents it,
// EXEC retires it (advances or jumps the PC). Supports stall, halt/resume and a sync active-low reset.
module fetch_ctrl #(
   parameter logic [3:0] RESET_PC = 4'h0
) (
   input  logic       clk_cpu,
   input  logic       reset,
   input  logic       stall,
   input  logic       halt_req,
   input  logic       resume,
   input  logic       jmp_en,
   input  logic [3:0] jmp_adrs,
   input  logic [7:0] rom_dat,
   output logic [3:0] rom_adrs,
   output logic [3:0] pc_out,
   output logic [3:0] op,
   output logic [3:0] im,
   output logic       exec_strobe,
   output logic       halted,
   output logic [7:0] instr_cnt
);

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 8;

   typedef enum logic [1:0] {
      S_FETCH  = 2'd0,
      S_DECODE = 2'd1,
      S_EXEC   = 2'd2,
      S_HALT   = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0]   ir_q, ir_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   // State register; reset overrides every other input.
   always_ff @(posedge clk_cpu) begin
      if (!reset) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= DATA_W'(0);
         cnt_q   <= CNT_W'(0);
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic; stall freezes every active phase but not HALT.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_FETCH: begin
            if (!stall) begin
               ir_d    = rom_dat;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (!stall) begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            if (!stall) begin
               pc_d    = jmp_en ? jmp_adrs : pc_q + ADDR_W'(1);
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = halt_req ? S_HALT : S_FETCH;
            end
         end
         S_HALT: begin
            if (resume) begin
               state_d = S_FETCH;
            end
         end
         default: state_d = S_FETCH;
      endcase
   end

   assign rom_adrs    = pc_q;
   assign pc_out      = pc_q;
   assign op          = ir_q[7:4];
   assign im          = ir_q[3:0];
   assign exec_strobe = (state_q == S_EXEC) && !stall;
   assign halted      = (state_q == S_HALT);
   assign instr_cnt   = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl with a small combinational ROM model.
module tb_fetch_ctrl;

   logic       clk_cpu = 1'b0;
   logic       reset;
   logic       stall;
   logic       halt_req;
   logic       resume;
   logic       jmp_en;
   logic [3:0] jmp_adrs;
   logic [7:0] rom_dat;
   logic [3:0] rom_adrs;
   logic [3:0] pc_out;
   logic [3:0] op;
   logic [3:0] im;
   logic       exec_strobe;
   logic       halted;
   logic [7:0] instr_cnt;

   logic [7:0] rom [16];
   int         total = 0;
   int         bad   = 0;

   always #5 clk_cpu = ~clk_cpu;

   assign rom_dat = rom[rom_adrs];

   fetch_ctrl #(.RESET_PC(4'h0)) dut (
      .clk_cpu     (clk_cpu),
      .reset       (reset),
      .stall       (stall),
      .halt_req    (halt_req),
      .resume      (resume),
      .jmp_en      (jmp_en),
      .jmp_adrs    (jmp_adrs),
      .rom_dat     (rom_dat),
      .rom_adrs    (rom_adrs),
      .pc_out      (pc_out),
      .op          (op),
      .im          (im),
      .exec_strobe (exec_strobe),
      .halted      (halted),
      .instr_cnt   (instr_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_cpu);
      #1;
   endtask

   // One unstalled instruction starting in FETCH; jump applied in EXEC when j is set.
   task automatic run_instr(input logic j, input logic [3:0] a);
      step();
      step();
      jmp_en   = j;
      jmp_adrs = a;
      step();
      jmp_en   = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) rom[i] = {4'(i), 4'(15 - i)};
      rom[0] = 8'h3F;

      reset = 1'b0; stall = 1'b0; halt_req = 1'b0; resume = 1'b0;
      jmp_en = 1'b0; jmp_adrs = 4'h0;
      step();
      step();
      chk("rst_pc", 32'(pc_out), 32'h0);
      chk("rst_cnt", 32'(instr_cnt), 32'h0);
      chk("rst_op", 32'(op), 32'h0);
      chk("rst_im", 32'(im), 32'h0);
      chk("rst_exec", 32'(exec_strobe), 32'h0);
      chk("rst_halted", 32'(halted), 32'h0);

      // First instruction: 0x3F at pc 0
      reset = 1'b1;
      #1;
      chk("first_rom_adrs", 32'(rom_adrs), 32'h0);
      chk("c1_exec", 32'(exec_strobe), 32'h0);
      step();
      chk("c2_op", 32'(op), 32'h3);
      chk("c2_im", 32'(im), 32'hF);
      chk("c2_exec", 32'(exec_strobe), 32'h0);
      step();
      chk("c3_exec", 32'(exec_strobe), 32'h1);
      chk("c3_pc", 32'(pc_out), 32'h0);
      step();
      chk("i1_pc", 32'(pc_out), 32'h1);
      chk("i1_cnt", 32'(instr_cnt), 32'h1);
      chk("i1_exec", 32'(exec_strobe), 32'h0);

      // Free-run 15 more: pc wraps to 0, count reaches 16, strobe every third cycle
      for (int k = 0; k < 15; k++) begin
         chk("fr_exec_f", 32'(exec_strobe), 32'h0);
         step();
         chk("fr_exec_d", 32'(exec_strobe), 32'h0);
         step();
         chk("fr_exec_e", 32'(exec_strobe), 32'h1);
         step();
      end
      chk("fr_pc_wrap", 32'(pc_out), 32'h0);
      chk("fr_cnt", 32'(instr_cnt), 32'd16);

      // Jump in EXEC at pc 2 to 0xA
      run_instr(1'b0, 4'h0);
      run_instr(1'b0, 4'h0);
      chk("pre_jmp_pc", 32'(pc_out), 32'h2);
      run_instr(1'b1, 4'hA);
      chk("jmp_rom_adrs", 32'(rom_adrs), 32'hA);
      chk("jmp_cnt", 32'(instr_cnt), 32'd19);
      run_instr(1'b1, 4'h2);
      chk("jmp_back_pc", 32'(pc_out), 32'h2);

      // jmp_en in DECODE ignored
      step();
      jmp_en = 1'b1; jmp_adrs = 4'hA;
      step();
      jmp_en = 1'b0;
      step();
      chk("dec_jmp_ign_pc", 32'(pc_out), 32'h3);
      chk("dec_jmp_ign_cnt", 32'(instr_cnt), 32'd21);

      // Stall 5 cycles in DECODE, halt_req meanwhile must not be remembered
      step();
      chk("stall_op", 32'(op), 32'h3);
      chk("stall_im", 32'(im), 32'hC);
      stall = 1'b1; halt_req = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("stall_d_pc", 32'(pc_out), 32'h3);
         chk("stall_d_exec", 32'(exec_strobe), 32'h0);
         chk("stall_d_ir", 32'({op, im}), 32'h3C);
      end
      stall = 1'b0; halt_req = 1'b0;
      #1;
      chk("stall_d_still_dec", 32'(exec_strobe), 32'h0);
      step();
      chk("stall_exec_after", 32'(exec_strobe), 32'h1);
      stall = 1'b1; jmp_en = 1'b1; jmp_adrs = 4'hE;
      #1;
      chk("stall_e_exec", 32'(exec_strobe), 32'h0);
      step();
      chk("stall_e_pc", 32'(pc_out), 32'h3);
      chk("stall_e_cnt", 32'(instr_cnt), 32'd21);
      stall = 1'b0; jmp_en = 1'b0;
      #1;
      chk("stall_e_release", 32'(exec_strobe), 32'h1);
      step();
      chk("post_stall_pc", 32'(pc_out), 32'h4);
      chk("post_stall_cnt", 32'(instr_cnt), 32'd22);
      chk("no_halt_memory", 32'(halted), 32'h0);

      // halt_req + jmp_en together in EXEC
      step();
      step();
      halt_req = 1'b1; jmp_en = 1'b1; jmp_adrs = 4'h7;
      step();
      halt_req = 1'b0; jmp_en = 1'b0;
      chk("halt_halted", 32'(halted), 32'h1);
      chk("halt_pc", 32'(pc_out), 32'h7);
      chk("halt_cnt", 32'(instr_cnt), 32'd23);
      for (int k = 0; k < 10; k++) begin
         stall = k[0];
         step();
         chk("halt_hold", 32'(halted), 32'h1);
         chk("halt_hold_pc", 32'(pc_out), 32'h7);
         chk("halt_hold_cnt", 32'(instr_cnt), 32'd23);
         chk("halt_hold_exec", 32'(exec_strobe), 32'h0);
      end
      stall = 1'b0;
      resume = 1'b1;
      step();
      resume = 1'b0;
      chk("resume_halted", 32'(halted), 32'h0);
      chk("resume_rom_adrs", 32'(rom_adrs), 32'h7);
      // resume in FETCH has no effect
      resume = 1'b1;
      step();
      resume = 1'b0;
      chk("resume_fetch_ign", 32'(halted), 32'h0);
      chk("resume_fetch_op", 32'(op), 32'h7);
      step();
      step();
      chk("after_resume_pc", 32'(pc_out), 32'h8);
      chk("after_resume_cnt", 32'(instr_cnt), 32'd24);

      // instr_cnt wrap at 256
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("rst2_cnt", 32'(instr_cnt), 32'h0);
      for (int k = 0; k < 255; k++) run_instr(1'b0, 4'h0);
      chk("cnt_ff", 32'(instr_cnt), 32'hFF);
      chk("cnt_ff_pc", 32'(pc_out), 32'hF);
      run_instr(1'b0, 4'h0);
      chk("cnt_wrap", 32'(instr_cnt), 32'h00);
      chk("cnt_wrap_pc", 32'(pc_out), 32'h0);

      // Reset during EXEC with pc 5, count 9
      reset = 1'b0;
      step();
      reset = 1'b1;
      for (int k = 0; k < 8; k++) run_instr(1'b0, 4'h0);
      run_instr(1'b1, 4'h5);
      chk("pre_rst_pc", 32'(pc_out), 32'h5);
      chk("pre_rst_cnt", 32'(instr_cnt), 32'h9);
      step();
      step();
      chk("pre_rst_exec", 32'(exec_strobe), 32'h1);
      reset = 1'b0; stall = 1'b1; jmp_en = 1'b1; halt_req = 1'b1;
      step();
      reset = 1'b1; stall = 1'b0; jmp_en = 1'b0; halt_req = 1'b0;
      chk("mid_rst_pc", 32'(pc_out), 32'h0);
      chk("mid_rst_cnt", 32'(instr_cnt), 32'h0);
      chk("mid_rst_exec", 32'(exec_strobe), 32'h0);
      chk("mid_rst_halted", 32'(halted), 32'h0);
      chk("mid_rst_ir", 32'({op, im}), 32'h00);
      chk("mid_rst_rom_adrs", 32'(rom_adrs), 32'h0);
      step();
      chk("mid_rst_refetch", 32'({op, im}), 32'h3F);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
